// File: rtl/activation_arbiter_if.sv
// Handshake bundle for activation_arbiter: two requester streams in,
// one result stream out. The slave modport is the arbiter's view; the
// master modport is the view of the surrounding requesters and sink.
interface activation_arbiter_if;
    logic [31:0] s0_data;
    logic        s0_valid;
    logic        s0_last;
    logic        s0_ready;
    logic [31:0] s1_data;
    logic        s1_valid;
    logic        s1_last;
    logic        s1_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_id;
    logic        m_ready;

    modport slave (
        input  s0_data, s0_valid, s0_last,
        output s0_ready,
        input  s1_data, s1_valid, s1_last,
        output s1_ready,
        output m_data, m_valid, m_last, m_id,
        input  m_ready
    );

    modport master (
        output s0_data, s0_valid, s0_last,
        input  s0_ready,
        output s1_data, s1_valid, s1_last,
        input  s1_ready,
        input  m_data, m_valid, m_last, m_id,
        output m_ready
    );
endinterface

// File: rtl/activation_arbiter.sv
// activation_arbiter: packet-locked round-robin arbiter between two
// requesters feeding one shared LeakyReLU (alpha = 0x3DCCCCCD, 0.1f).
// The only pipeline stage is the m_* output register.
// Optional feature: define ACT_NEG_COUNT_EN to add the saturating
// neg_count output (accepted beats with a negative operand).
module activation_arbiter (
    input  logic                 clk,
    input  logic                 rst,
    activation_arbiter_if.slave  bus,
    output logic                 busy
`ifdef ACT_NEG_COUNT_EN
    ,
    output logic [15:0]          neg_count
`endif
);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    // Mantissa of 0.1f with hidden bit; its biased exponent is 123.
    localparam logic [23:0] ALPHA_MANT = 24'hCCCCCD;

    state_t      state_q, state_d;
    logic        rr_q, rr_d;
    logic [31:0] m_data_q, m_data_d;
    logic        m_valid_q, m_valid_d;
    logic        m_last_q, m_last_d;
    logic        m_id_q, m_id_d;

    logic        out_ready;
    logic        sel_valid;
    logic        sel_last;
    logic [31:0] sel_data;
    logic [31:0] act_result;
    logic        accept;

    // LeakyReLU on IEEE-754 single: positives, infinities and NaNs pass
    // through; negatives are scaled by 0.1f with round-to-nearest-even.
    // Zero/denormal negatives and underflowing products become -0.0.
    function automatic logic [31:0] leaky_relu(input logic [31:0] x);
        logic [47:0]       prod;
        logic [22:0]       frac;
        logic              guard;
        logic              sticky;
        logic [23:0]       rnd;
        logic signed [9:0] exp_r;
        leaky_relu = x;
        if (x[31] && (x[30:23] != 8'hFF)) begin
            if (x[30:23] == 8'h00) begin
                leaky_relu = {1'b1, 31'd0};
            end else begin
                prod = {24'd0, 1'b1, x[22:0]} * {24'd0, ALPHA_MANT};
                if (prod[47]) begin
                    frac   = prod[46:24];
                    guard  = prod[23];
                    sticky = |prod[22:0];
                    exp_r  = $signed({2'b00, x[30:23]}) - 10'sd3;
                end else begin
                    frac   = prod[45:23];
                    guard  = prod[22];
                    sticky = |prod[21:0];
                    exp_r  = $signed({2'b00, x[30:23]}) - 10'sd4;
                end
                rnd = {1'b0, frac} + {23'd0, guard & (sticky | frac[0])};
                if (rnd[23]) begin
                    exp_r = exp_r + 10'sd1;
                end
                if (exp_r < 10'sd1) begin
                    leaky_relu = {1'b1, 31'd0};
                end else begin
                    leaky_relu = {1'b1, exp_r[7:0], rnd[22:0]};
                end
            end
        end
    endfunction

    // Route the granted requester into the single shared LeakyReLU.
    always_comb begin
        out_ready  = !m_valid_q || bus.m_ready;
        sel_valid  = (state_q == GRANT1) ? bus.s1_valid : bus.s0_valid;
        sel_last   = (state_q == GRANT1) ? bus.s1_last  : bus.s0_last;
        sel_data   = (state_q == GRANT1) ? bus.s1_data  : bus.s0_data;
        accept     = (state_q != IDLE) && sel_valid && out_ready;
        act_result = leaky_relu(sel_data);
    end

    assign bus.s0_ready = (state_q == GRANT0) && out_ready;
    assign bus.s1_ready = (state_q == GRANT1) && out_ready;
    assign bus.m_data   = m_data_q;
    assign bus.m_valid  = m_valid_q;
    assign bus.m_last   = m_last_q;
    assign bus.m_id     = m_id_q;
    assign busy         = (state_q != IDLE) || m_valid_q;

    // Next state: arbitrate in IDLE, hold the grant until a last beat.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        case (state_q)
            IDLE: begin
                if (bus.s0_valid && bus.s1_valid) begin
                    state_d = rr_q ? GRANT1 : GRANT0;
                end else if (bus.s0_valid) begin
                    state_d = GRANT0;
                end else if (bus.s1_valid) begin
                    state_d = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                if (accept && sel_last) begin
                    state_d = IDLE;
                    rr_d    = (state_q == GRANT0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register: load on accept, otherwise drain on m_ready.
    always_comb begin
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        m_id_d    = m_id_q;
        if (accept) begin
            m_data_d  = act_result;
            m_valid_d = 1'b1;
            m_last_d  = sel_last;
            m_id_d    = (state_q == GRANT1);
        end else if (bus.m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    // State and output registers; reset wins over a same-cycle accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_q      <= 1'b0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_id_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_id_q    <= m_id_d;
        end
    end

`ifdef ACT_NEG_COUNT_EN
    logic [15:0] neg_count_q, neg_count_d;

    // Saturating count of accepted beats carrying a negative operand.
    always_comb begin
        neg_count_d = neg_count_q;
        if (accept && sel_data[31] && (neg_count_q != '1)) begin
            neg_count_d = neg_count_q + 16'd1;
        end
    end

    // Negative-beat counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            neg_count_q <= '0;
        end else begin
            neg_count_q <= neg_count_d;
        end
    end

    assign neg_count = neg_count_q;
`else
`endif

endmodule

// File: tb/tb_activation_arbiter.sv
// Bench for activation_arbiter: directed scenarios plus randomized
// packet traffic, checked against a behavioural model that computes
// LeakyReLU in real arithmetic and tracks the output beat per cycle.
module tb_activation_arbiter;

    logic clk;
    logic rst;
    logic busy;
`ifdef ACT_NEG_COUNT_EN
    logic [15:0] neg_count;
`endif

    activation_arbiter_if bus ();

    activation_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .busy      (busy)
`ifdef ACT_NEG_COUNT_EN
        ,
        .neg_count (neg_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [32:0] src0[$];
    logic [32:0] src1[$];
    logic        mv;
    logic [31:0] md;
    logic        ml;
    logic        mi;
    logic [15:0] exp_neg;
    logic        pkt_open;
    logic        owner;

    // Logs from the most recent traffic run
    int          acc_id[$];
    int          acc_cyc[$];
    logic [31:0] out_data[$];
    logic        out_id[$];
    logic        out_last[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // LeakyReLU computed through double precision, then rounded to single.
    function automatic logic [31:0] ref_leaky(input logic [31:0] x);
        real         p;
        logic [63:0] d;
        int          e;
        logic [23:0] m;
        logic        up;
        if (!x[31]) return x;
        if (x[30:23] == 8'hFF) return x;
        if (x[30:23] == 8'h00) return 32'h8000_0000;
        d = {1'b1, 11'(int'(x[30:23]) + 896), x[22:0], 29'd0};
        p = $bitstoreal(d) * $bitstoreal(64'h3FB99999A0000000);
        d = $realtobits(p);
        e = int'(d[62:52]) - 896;
        up = (d[28:0] > 29'h1000_0000) || ((d[28:0] == 29'h1000_0000) && d[29]);
        m = {1'b0, d[51:29]} + 24'(up);
        if (m[23]) e++;
        if (e < 1) return 32'h8000_0000;
        return {1'b1, 8'(e), m[22:0]};
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        case ($urandom_range(9))
            0: v = 32'h0000_0000;
            1: v = 32'h8000_0000;
            default: v = {1'($urandom_range(1)), 8'($urandom_range(250, 10)), 23'($urandom)};
        endcase
        return v;
    endfunction

    task automatic model_reset();
        mv = 1'b0; md = '0; ml = 1'b0; mi = 1'b0;
        exp_neg = '0; pkt_open = 1'b0; owner = 1'b0;
        src0.delete(); src1.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.s0_valid = 1'b0; bus.s1_valid = 1'b0; bus.m_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic push_pkt(input int who, input int len, input bit neg_only);
        logic [31:0] v;
        for (int i = 0; i < len; i++) begin
            v = rand_operand();
            if (neg_only) v = {1'b1, 8'($urandom_range(200, 100)), 23'($urandom)};
            if (who == 0) src0.push_back({(i == len - 1), v});
            else          src1.push_back({(i == len - 1), v});
        end
    endtask

    // Cycle engine: drives sources/sink from the queues, checks the DUT
    // against the model every cycle; rst_at >= 0 resets and returns.
    task automatic run_traffic(input int max_cyc, input int vpct, input int rpct,
                               input int stall_lo, input int stall_hi, input int rst_at);
        int          cyc;
        bit          done;
        bit          v0, v1, r0, r1, a0, a1, cons, idle_gap;
        logic [32:0] beat;
        cyc = 0; done = 0; idle_gap = 0;
        acc_id.delete(); acc_cyc.delete();
        out_data.delete(); out_id.delete(); out_last.delete();
        while (cyc < max_cyc) begin
            chk("m_valid", bus.m_valid, mv);
            if (mv) begin
                chk("m_data", bus.m_data, md);
                chk("m_last", bus.m_last, ml);
                chk("m_id", bus.m_id, mi);
            end
`ifdef ACT_NEG_COUNT_EN
            chk("neg_count", neg_count, exp_neg);
`endif
            if (src0.size() == 0 && src1.size() == 0 && !mv) begin
                done = 1;
                break;
            end
            v0 = (src0.size() > 0) && ($urandom_range(99) < vpct);
            v1 = (src1.size() > 0) && ($urandom_range(99) < vpct);
            bus.s0_valid = v0;
            bus.s0_data  = v0 ? src0[0][31:0] : $urandom;
            bus.s0_last  = v0 ? src0[0][32] : 1'($urandom_range(1));
            bus.s1_valid = v1;
            bus.s1_data  = v1 ? src1[0][31:0] : $urandom;
            bus.s1_last  = v1 ? src1[0][32] : 1'($urandom_range(1));
            bus.m_ready  = (cyc >= stall_lo && cyc < stall_hi) ? 1'b0 : ($urandom_range(99) < rpct);
            rst = (cyc == rst_at);
            #1;
            r0 = bus.s0_ready;
            r1 = bus.s1_ready;
            chk("ready_excl", r0 & r1, 0);
            if (mv && !bus.m_ready) chk("ready_stall", {r0, r1}, 0);
            if (idle_gap) chk("idle_gap", {r0, r1}, 0);
            if (pkt_open) chk("grant_lock", owner ? r0 : r1, 0);
            a0 = r0 && v0 && !rst;
            a1 = r1 && v1 && !rst;
            cons = mv && bus.m_ready;
            if (cons) begin
                out_data.push_back(bus.m_data);
                out_id.push_back(bus.m_id);
                out_last.push_back(bus.m_last);
            end
            @(posedge clk);
            if (rst) begin
                model_reset();
                @(negedge clk);
                rst = 1'b0;
                done = 1;
                break;
            end
            idle_gap = 0;
            if (a0 || a1) begin
                beat = a1 ? src1.pop_front() : src0.pop_front();
                md = ref_leaky(beat[31:0]);
                mv = 1'b1;
                ml = beat[32];
                mi = a1;
                if (beat[31] && exp_neg != 16'hFFFF) exp_neg++;
                acc_id.push_back(a1 ? 1 : 0);
                acc_cyc.push_back(cyc);
                pkt_open = !beat[32];
                owner    = a1;
                idle_gap = beat[32];
            end else if (cons) begin
                mv = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
        chk("no_timeout", done, 1);
    endtask

    initial begin
        rst = 1'b1;
        bus.s0_valid = 1'b0; bus.s0_data = '0; bus.s0_last = 1'b0;
        bus.s1_valid = 1'b0; bus.s1_data = '0; bus.s1_last = 1'b0;
        bus.m_ready  = 1'b0;
        model_reset();

        // Reset values, with both requesters pushing while still in reset
        bus.s0_valid = 1'b1; bus.s1_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_data", bus.m_data, 32'h0);
        chk("rst_m_last", bus.m_last, 0);
        chk("rst_m_id", bus.m_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_s0_ready", bus.s0_ready, 0);
        chk("rst_s1_ready", bus.s1_ready, 0);
`ifdef ACT_NEG_COUNT_EN
        chk("rst_neg_count", neg_count, 0);
`endif
        do_reset();

        // Single beat 3.0 on s0
        src0.push_back({1'b1, 32'h4040_0000});
        run_traffic(50, 100, 100, -1, -1, -1);
        chk("t34_acc_cyc", acc_cyc[0], 1);
        chk("t34_count", out_data.size(), 1);
        chk("t34_data", out_data[0], 32'h4040_0000);
        chk("t34_id", out_id[0], 0);
        chk("t34_last", out_last[0], 1);
        chk("t34_busy_end", busy, 0);

        // Negative scaling and zero on s1
        do_reset();
        src1.push_back({1'b0, 32'hC040_0000});
        src1.push_back({1'b1, 32'h0000_0000});
        run_traffic(50, 100, 100, -1, -1, -1);
        chk("t35_count", out_data.size(), 2);
        chk("t35_neg3", out_data[0], 32'hBE99_999A);
        chk("t35_id", out_id[0], 1);
        chk("t35_zero", out_data[1], 32'h0);

        // Both requesters valid from reset, 3-beat packets each
        do_reset();
        push_pkt(0, 3, 0);
        push_pkt(1, 3, 0);
        run_traffic(100, 100, 100, -1, -1, -1);
        chk("t36_count", acc_id.size(), 6);
        for (int i = 0; i < 6; i++) begin
            chk("t36_acc_id", acc_id[i], (i < 3) ? 0 : 1);
            chk("t36_acc_cyc", acc_cyc[i], (i < 3) ? i + 1 : i + 2);
        end

        // Downstream stall of 4 cycles inside a 6-beat packet
        do_reset();
        push_pkt(0, 6, 0);
        begin
            logic [32:0] pkt[$];
            pkt = src0;
            run_traffic(100, 100, 100, 3, 7, -1);
            chk("t37_count", out_data.size(), 6);
            for (int i = 0; i < 6; i++) begin
                chk("t37_data", out_data[i], ref_leaky(pkt[i][31:0]));
                chk("t37_acc_cyc", acc_cyc[i], (i < 2) ? i + 1 : i + 5);
            end
        end

        // Reset during the second beat of a 3-beat s0 packet, after rr moved to s1
        do_reset();
        src0.push_back({1'b1, 32'hBF80_0000});
        push_pkt(0, 3, 1);
        run_traffic(50, 100, 100, -1, -1, 4);
        chk("t38_m_valid", bus.m_valid, 0);
        chk("t38_busy", busy, 0);
        chk("t38_s0_ready", bus.s0_ready, 0);
        chk("t38_s1_ready", bus.s1_ready, 0);
`ifdef ACT_NEG_COUNT_EN
        chk("t38_neg_zero", neg_count, 0);
`endif
        push_pkt(0, 3, 1);
        src1.push_back({1'b1, 32'h3F80_0000});
        run_traffic(100, 100, 100, -1, -1, -1);
        chk("t38_rr_first", acc_id[0], 0);
        chk("t38_rr_second", acc_id[3], 1);
`ifdef ACT_NEG_COUNT_EN
        chk("t38_neg_three", neg_count, 3);
`endif

        // Randomized traffic with random valid gaps and backpressure
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int p = 0; p < 20; p++) begin
                push_pkt(0, $urandom_range(4, 1), 0);
                push_pkt(1, $urandom_range(4, 1), 0);
            end
            run_traffic(5000, 50 + 20 * r, 90 - 30 * r, -1, -1, -1);
            chk("rand_beats", acc_id.size(), out_data.size());
            chk("rand_busy_end", busy, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
